inst_fetch_ctrl: RTL and testbench

Sequencer for the byte-addressed 16-bit instruction memory.
- Loads a program into the memory byte by byte through a valid/ready load port.
- On start, fetches instructions from RESET_PC into a one-entry output slot with valid/ready handshake to decode.
- Supports branch redirect with flush; stops on a HALT opcode.
- Sits between program loader/test harness, instruction memory and the decode stage.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_ctrl_fetch_slot.sv | 52 +++++
 rtl/inst_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned INST_BYTES      = 2;
  localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;
  localparam int unsigned OPC_MSB         = 15;
  localparam int unsigned OPC_LSB         = 12;

  function automatic logic [3:0] opcode(input logic [15:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_slot.sv
// One-entry valid/ready holding register between fetch and decode.
module fetch_slot #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [15:0]       din,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [15:0]       dout,
  output logic [ADDR_W-1:0] pc_out
);

  logic              valid_q, valid_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
      pc_d    = pc_in;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid  = valid_q;
  assign dout   = data_q;
  assign pc_out = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: program load port, PC/FSM control and memory-port mux.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       MEM_BYTES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]        HALT_OP   = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [15:0]       mem_inst,
  output logic              inst_valid,
  output logic [15:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned       PTR_W     = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] EVEN_MASK = ADDR_MASK & ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INST_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  load_ptr_q, load_ptr_d;
  logic              slot_load, slot_flush, slot_is_halt, load_fire;

  assign load_fire    = load_valid && (state_q != ST_RUN);
  assign slot_is_halt = inst_valid && (opcode(inst_out) == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  // A load beat outranks start; redirect outranks both halt and capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_ptr_d = load_ptr_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (load_fire) begin
          load_ptr_d = load_ptr_q + PTR_W'(1);
        end else if (start) begin
          state_d    = ST_RUN;
          pc_d       = RESET_PC;
          load_ptr_d = '0;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc & EVEN_MASK;
          slot_flush = 1'b1;
        end else if (slot_is_halt) begin
          if (inst_ready) begin
            slot_flush = 1'b1;
            state_d    = ST_HALT;
          end
        end else if (!inst_valid || inst_ready) begin
          slot_load = 1'b1;
          pc_d      = (pc_q + STEP) & ADDR_MASK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q != ST_RUN);
    halted     = (state_q == ST_HALT);
    mem_rw     = load_fire;
    mem_addr   = load_fire ? ADDR_W'(load_ptr_q) : pc_q;
    mem_wdata  = load_fire ? load_data : '0;
  end

  assign pc = pc_q;

  fetch_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (slot_load),
    .flush  (slot_flush),
    .ready  (inst_ready),
    .din    (mem_inst),
    .pc_in  (pc_q),
    .valid  (inst_valid),
    .dout   (inst_out),
    .pc_out (inst_pc)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a byte memory and expected-instruction queue.
module tb_inst_fetch_ctrl;

  logic        clk, rst_n, start, load_valid, load_ready, mem_rw;
  logic [7:0]  load_data, mem_wdata;
  logic [15:0] mem_addr, mem_inst, inst_out, inst_pc, redirect_pc, pc;
  logic        inst_valid, inst_ready, redirect_valid, halted;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  inst_fetch_ctrl #(.ADDR_W(16), .MEM_BYTES(64), .RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_inst(mem_inst),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rw) mem[mem_addr[5:0]] <= mem_wdata;
  assign mem_inst = {mem[mem_addr[5:0]], mem[mem_addr[5:0] + 6'd1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] a);
    logic [5:0] a1;
    a1 = a + 6'd1;
    exp_q.push_back({10'd0, a, ref_mem[a], ref_mem[a1]});
  endtask

  // Called at posedge+1; one beat per cycle, address checked against expectation.
  task automatic load_byte(input logic [7:0] b, input logic [5:0] a);
    load_valid = 1'b1;
    load_data  = b;
    @(negedge clk);
    chk("ld_ready", load_ready, 1);
    chk("ld_rw", mem_rw, 1);
    chk("ld_addr", mem_addr, a);
    chk("ld_wdata", mem_wdata, b);
    ref_mem[a] = b;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; accepts n instructions, returns negedges observed.
  task automatic consume(input int n, output int cycles);
    int got = 0;
    logic [31:0] e;
    cycles = 0;
    inst_ready = 1'b1;
    while (got < n && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) chk("extra_inst", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, {16'd0, e[31:16]});
          chk("inst_out", inst_out, {16'd0, e[15:0]});
        end
        got++;
      end
    end
    chk("handshakes", got, n);
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_ipc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_rw", mem_rw, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-byte program ending in a HALT opcode
    load_byte(8'h12, 6'd0);
    load_byte(8'h34, 6'd1);
    load_byte(8'hF0, 6'd2);
    load_byte(8'h00, 6'd3);
    load_valid = 1'b0;
    @(negedge clk);
    chk("idle_rw", mem_rw, 0);
    chk("idle_wdata", mem_wdata, 0);
    @(posedge clk); #1;

    // start together with a load beat: load wins, written at load_ptr=4
    start = 1'b1;
    load_byte(8'h00, 6'd4);
    start = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    chk("ld_start_idle", load_ready, 1);
    chk("ld_start_valid", inst_valid, 0);
    @(posedge clk); #1;

    inst_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("run_ready", load_ready, 0);
    chk("lat_valid0", inst_valid, 0);
    @(posedge clk); #1;
    push_exp(6'd0); push_exp(6'd2);
    consume(2, cyc);
    chk("lat_cycles", cyc, 2);
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_valid", inst_valid, 0);
    chk("halt_pc", pc, 4);
    chk("halt_ldready", load_ready, 1);
    @(negedge clk);
    chk("halt_pc_hold", pc, 4);
    @(posedge clk); #1;

    // Full 64-byte image (one HALT at 0x20), plus a 65th beat to show pointer wrap
    for (int i = 0; i < 65; i++)
      load_byte((i % 64 == 32) ? 8'hF0 : 8'(i % 64), 6'(i % 64));
    load_valid = 1'b0;

    // Backpressure
    pulse_start();
    @(negedge clk);
    chk("bp_halted", halted, 0);
    chk("bp_valid0", inst_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", inst_valid, 1);
      chk("bp_out", inst_out, 16'h0001);
      chk("bp_ipc", inst_pc, 0);
      chk("bp_pc", pc, 2);
      chk("bp_rw", mem_rw, 0);
    end
    @(posedge clk); #1;
    for (int a = 0; a <= 8; a += 2) push_exp(6'(a));
    consume(5, cyc);
    chk("bp_rate", cyc, 5);

    // Redirect while slot is full
    @(negedge clk);
    chk("rd_pre_ipc", inst_pc, 10);
    chk("rd_pre_pc", pc, 12);
    @(posedge clk); #1;
    do_redirect(16'h0015);
    @(negedge clk);
    chk("rd_flush", inst_valid, 0);
    chk("rd_pc", pc, 16'h0014);
    @(negedge clk);
    chk("rd_valid", inst_valid, 1);
    chk("rd_ipc", inst_pc, 16'h0014);
    chk("rd_out", inst_out, 16'h1415);
    @(posedge clk); #1;

    // Wrap 62 -> 0 -> 2
    do_redirect(16'd62);
    push_exp(6'd62); push_exp(6'd0); push_exp(6'd2);
    consume(3, cyc);

    // Redirect on the HALT handshake cycle
    do_redirect(16'd30);
    push_exp(6'd30);
    consume(1, cyc);
    @(negedge clk);
    chk("hw_out", inst_out, 16'hF021);
    chk("hw_pc", pc, 34);
    @(negedge clk);
    chk("hw_pc_hold", pc, 34);
    chk("hw_ipc", inst_pc, 32);
    chk("hw_valid", inst_valid, 1);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    do_redirect(16'd0);
    inst_ready = 1'b0;
    @(negedge clk);
    chk("rh_halted", halted, 0);
    chk("rh_valid", inst_valid, 0);
    chk("rh_pc", pc, 0);
    @(negedge clk);
    chk("rh_ipc", inst_pc, 0);
    chk("rh_valid1", inst_valid, 1);

    // Async reset mid-RUN, released away from the clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", inst_valid, 0);
    chk("ar_out", inst_out, 0);
    chk("ar_ipc", inst_pc, 0);
    chk("ar_halted", halted, 0);
    chk("ar_pc", pc, 0);
    chk("ar_idle", load_ready, 1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_idle", load_ready, 1);
    chk("ar_post_valid", inst_valid, 0);
    @(posedge clk); #1;
    pulse_start();
    push_exp(6'd0); push_exp(6'd2);
    consume(2, cyc);
    chk("ar_restart_lat", cyc, 3);
    chk("q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
